// File: rtl/sad_pkg.sv
// Shared constants and helpers for the systolic SAD PE row.
// Latency: n/a (package only).
// Backpressure: n/a.
package sad_pkg;

  localparam int DEFAULT_PIXEL_W = 8;
  localparam int DEFAULT_ACC_W   = 16;
  // Widest pixel absdiff() handles; callers zero-extend narrower pixels.
  localparam int MAX_PIXEL_W     = 16;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Unsigned |a - b| using one extra bit to detect the sign of a - b.
  function automatic logic [MAX_PIXEL_W-1:0] absdiff(input logic [MAX_PIXEL_W-1:0] a,
                                                     input logic [MAX_PIXEL_W-1:0] b);
    logic [MAX_PIXEL_W:0] d_ab;
    logic [MAX_PIXEL_W:0] d_ba;
    d_ab = {1'b0, a} - {1'b0, b};
    d_ba = {1'b0, b} - {1'b0, a};
    return d_ab[MAX_PIXEL_W] ? d_ba[MAX_PIXEL_W-1:0] : d_ab[MAX_PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/sad_pe_array_if.sv
// Bus between the search-window feeder, the SAD PE row and the MV decision logic.
// Latency: n/a (wires only).
// Backpressure: none; the row accepts a sample on every cycle in_valid is high.
// master: drives in_valid/new_dist/r/s1/s2/s1s2_mux, observes results.
// slave : the PE row; consumes samples, drives r_pipe/acc_*/best_*/overrun.
interface sad_pe_array_if
  import sad_pkg::*;
#(
  parameter int PIXEL_W = DEFAULT_PIXEL_W,
  parameter int NUM_PE  = 4,
  parameter int ACC_W   = DEFAULT_ACC_W,
  parameter int IDX_W   = clog2(NUM_PE)
);
  logic                    in_valid;
  logic                    new_dist;
  logic [PIXEL_W-1:0]      r;
  logic [PIXEL_W-1:0]      s1;
  logic [PIXEL_W-1:0]      s2;
  logic [NUM_PE-1:0]       s1s2_mux;
  logic [PIXEL_W-1:0]      r_pipe;
  logic [NUM_PE-1:0]       acc_valid;
  logic [NUM_PE*ACC_W-1:0] acc_result;
  logic                    best_valid;
  logic [ACC_W-1:0]        best_sad;
  logic [IDX_W-1:0]        best_idx;
  logic                    overrun;

  modport master (
    output in_valid, new_dist, r, s1, s2, s1s2_mux,
    input  r_pipe, acc_valid, acc_result, best_valid, best_sad, best_idx, overrun
  );

  modport slave (
    input  in_valid, new_dist, r, s1, s2, s1s2_mux,
    output r_pipe, acc_valid, acc_result, best_valid, best_sad, best_idx, overrun
  );
endinterface

// File: rtl/sad_pe.sv
// One systolic SAD PE: skew register, s1/s2 mux, |r-s|, block accumulator, result latch.
// Latency: result and acc_valid appear the cycle after the sample that completes the block.
// Backpressure: none; in_vld low simply holds state. SAD_SATURATE_EN selects saturating accumulation.
// Ports: in_* = (valid,new_dist,r) tuple seen by this PE; skew_* = same tuple one cycle later
//        for the next PE; s1/s2/sel undelayed; acc_valid/acc_result/overrun per PE.
module sad_pe
  import sad_pkg::*;
#(
  parameter int PIXEL_W      = DEFAULT_PIXEL_W,
  parameter int ACC_W        = DEFAULT_ACC_W,
  parameter int BLOCK_PIXELS = 16,
  parameter int CNT_W        = clog2(BLOCK_PIXELS + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_vld,
  input  logic               in_nd,
  input  logic [PIXEL_W-1:0] in_r,
  input  logic [PIXEL_W-1:0] s1,
  input  logic [PIXEL_W-1:0] s2,
  input  logic               sel,
  output logic               skew_vld,
  output logic               skew_nd,
  output logic [PIXEL_W-1:0] skew_r,
  output logic               acc_valid,
  output logic [ACC_W-1:0]   acc_result,
  output logic               overrun
);

  logic               vld_q, vld_d, nd_q, nd_d;
  logic [PIXEL_W-1:0] r_q, r_d;
  logic [ACC_W-1:0]   acc_q, acc_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               av_q, av_d, ovr_q, ovr_d;

  logic [PIXEL_W-1:0] s_sel;
  logic [ACC_W-1:0]   ad;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_next;

  assign s_sel = sel ? s2 : s1;
  assign ad    = ACC_W'(absdiff(MAX_PIXEL_W'(in_r), MAX_PIXEL_W'(s_sel)));
  assign sum   = {1'b0, acc_q} + {1'b0, ad};

`ifdef SAD_SATURATE_EN
  assign acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_comb begin
    vld_d = in_vld;
    nd_d  = in_nd;
    r_d   = in_r;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    av_d  = 1'b0;
    ovr_d = ovr_q;
    if (in_vld) begin
      if (in_nd) begin
        // A restart silently drops any partial block.
        acc_d = ad;
        cnt_d = CNT_W'(1);
      end else if (cnt_q < CNT_W'(BLOCK_PIXELS)) begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BLOCK_PIXELS - 1)) begin
          res_d = acc_next;
          av_d  = 1'b1;
        end
      end else begin
        // Block already complete and no restart: drop the sample, flag it.
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      nd_q  <= 1'b0;
      r_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      av_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      nd_q  <= nd_d;
      r_q   <= r_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      av_q  <= av_d;
      ovr_q <= ovr_d;
    end
  end

  assign skew_vld   = vld_q;
  assign skew_nd    = nd_q;
  assign skew_r     = r_q;
  assign acc_valid  = av_q;
  assign acc_result = res_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/sad_pe_array.sv
// Row of NUM_PE systolic SAD PEs plus a min stage reporting the best SAD and its PE index.
// Latency: acc_valid[i] BLOCK_PIXELS+i cycles after new_dist, best_valid one cycle after acc_valid[NUM_PE-1].
// Backpressure: none; gaps in in_valid stretch latency. SAD_SATURATE_EN selects saturating accumulation.
// Ports: clock, reset_n (sync, active low), bus (sad_pe_array_if.slave) carrying samples and results.
module sad_pe_array
  import sad_pkg::*;
#(
  parameter int PIXEL_W      = DEFAULT_PIXEL_W,
  parameter int NUM_PE       = 4,
  parameter int ACC_W        = DEFAULT_ACC_W,
  parameter int BLOCK_PIXELS = 16,
  parameter int CNT_W        = clog2(BLOCK_PIXELS + 1)
) (
  input logic            clock,
  input logic            reset_n,
  sad_pe_array_if.slave  bus
);

  localparam int IDX_W = clog2(NUM_PE);

  // Entry k of each chain is the tuple as seen by PE k (k cycles of skew).
  logic [NUM_PE:0]         vld_chain, nd_chain;
  logic [PIXEL_W-1:0]      r_chain [NUM_PE+1];
  logic [NUM_PE-1:0]       pe_av, pe_ovr;
  logic [ACC_W-1:0]        pe_res [NUM_PE];
  logic [NUM_PE*ACC_W-1:0] res_flat;

  assign vld_chain[0] = bus.in_valid;
  assign nd_chain[0]  = bus.new_dist;
  assign r_chain[0]   = bus.r;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    sad_pe #(
      .PIXEL_W(PIXEL_W), .ACC_W(ACC_W), .BLOCK_PIXELS(BLOCK_PIXELS), .CNT_W(CNT_W)
    ) u_pe (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_vld    (vld_chain[i]),
      .in_nd     (nd_chain[i]),
      .in_r      (r_chain[i]),
      .s1        (bus.s1),
      .s2        (bus.s2),
      .sel       (bus.s1s2_mux[i]),
      .skew_vld  (vld_chain[i+1]),
      .skew_nd   (nd_chain[i+1]),
      .skew_r    (r_chain[i+1]),
      .acc_valid (pe_av[i]),
      .acc_result(pe_res[i]),
      .overrun   (pe_ovr[i])
    );
  end

  // Only r leaves the row; the tail valid/new_dist skew has no consumer.
  logic unused_tail;
  assign unused_tail = vld_chain[NUM_PE] ^ nd_chain[NUM_PE];

  always_comb begin
    res_flat = '0;
    for (int i = 0; i < NUM_PE; i++) res_flat[i*ACC_W +: ACC_W] = pe_res[i];
  end

  // Min stage: fires when the last PE latches; every PE result is stable by then.
  logic             best_valid_q, best_valid_d;
  logic [ACC_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;

  always_comb begin
    best_valid_d = pe_av[NUM_PE-1];
    best_sad_d   = best_sad_q;
    best_idx_d   = best_idx_q;
    if (pe_av[NUM_PE-1]) begin
      best_sad_d = pe_res[0];
      best_idx_d = '0;
      // Strict less-than keeps the lowest index on ties.
      for (int i = 1; i < NUM_PE; i++) begin
        if (pe_res[i] < best_sad_d) begin
          best_sad_d = pe_res[i];
          best_idx_d = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      best_valid_q <= 1'b0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
    end else begin
      best_valid_q <= best_valid_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
    end
  end

  assign bus.r_pipe     = r_chain[NUM_PE];
  assign bus.acc_valid  = pe_av;
  assign bus.acc_result = res_flat;
  assign bus.best_valid = best_valid_q;
  assign bus.best_sad   = best_sad_q;
  assign bus.best_idx   = best_idx_q;
  assign bus.overrun    = |pe_ovr;

endmodule

// File: tb/tb_sad_pe_array.sv
// Bench for sad_pe_array: directed blocks, cycle-by-cycle model compare, literal spot checks.
module tb_sad_pe_array;
  localparam int PW = 8;
  localparam int NP = 4;
  localparam int AW = 16;
  localparam int BP = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  sad_pe_array_if #(.PIXEL_W(PW), .NUM_PE(NP), .ACC_W(AW)) bus ();
  sad_pe_array_if #(.PIXEL_W(PW), .NUM_PE(NP), .ACC_W(8))  bus8 ();

  sad_pe_array #(.PIXEL_W(PW), .NUM_PE(NP), .ACC_W(AW), .BLOCK_PIXELS(BP)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
  sad_pe_array #(.PIXEL_W(PW), .NUM_PE(NP), .ACC_W(8), .BLOCK_PIXELS(BP)) dut8 (
    .clock(clock), .reset_n(reset_n), .bus(bus8));

  // The narrow-accumulator instance sees exactly the same stimulus.
  assign bus8.in_valid = bus.in_valid;
  assign bus8.new_dist = bus.new_dist;
  assign bus8.r        = bus.r;
  assign bus8.s1       = bus.s1;
  assign bus8.s2       = bus.s2;
  assign bus8.s1s2_mux = bus.s1s2_mux;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int acc_add(input int a, input int b, input int w);
`ifdef SAD_SATURATE_EN
    return (a + b > (1 << w) - 1) ? (1 << w) - 1 : a + b;
`else
    return (a + b) % (1 << w);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_live = 0;
  int          m_cnt [NP], m_sum [NP], m_res [NP];
  bit [NP-1:0] m_av;
  bit          m_bv, m_ovr;
  int          m_bsad, m_bidx, m_rpipe;
  int          h_v [NP], h_nd [NP], h_r [NP];   // h_*[k]: input tuple from k+1 cycles ago

  always @(posedge clock) begin : p_model
    int v, nd, rr, s, ad, bs, bi;
    bit [NP-1:0] nav;
    m_live = 1;
    if (!reset_n) begin
      for (int i = 0; i < NP; i++) begin
        m_cnt[i] = 0; m_sum[i] = 0; m_res[i] = 0; h_v[i] = 0; h_nd[i] = 0; h_r[i] = 0;
      end
      m_av = '0; m_bv = 0; m_ovr = 0; m_bsad = 0; m_bidx = 0; m_rpipe = 0;
    end else begin
      m_bv = m_av[NP-1];
      if (m_av[NP-1]) begin
        bs = m_res[0]; bi = 0;
        for (int i = 1; i < NP; i++) if (m_res[i] < bs) begin bs = m_res[i]; bi = i; end
        m_bsad = bs; m_bidx = bi;
      end
      nav = '0;
      for (int i = 0; i < NP; i++) begin
        if (i == 0) begin v = int'(bus.in_valid); nd = int'(bus.new_dist); rr = int'(bus.r); end
        else begin v = h_v[i-1]; nd = h_nd[i-1]; rr = h_r[i-1]; end
        s  = bus.s1s2_mux[i] ? int'(bus.s2) : int'(bus.s1);
        ad = (rr > s) ? rr - s : s - rr;
        if (v != 0) begin
          if (nd != 0) begin m_sum[i] = ad; m_cnt[i] = 1; end
          else if (m_cnt[i] < BP) begin
            m_sum[i] = acc_add(m_sum[i], ad, AW);
            m_cnt[i]++;
            if (m_cnt[i] == BP) begin m_res[i] = m_sum[i]; nav[i] = 1'b1; end
          end else m_ovr = 1;
        end
      end
      m_av = nav;
      for (int k = NP - 1; k > 0; k--) begin h_v[k] = h_v[k-1]; h_nd[k] = h_nd[k-1]; h_r[k] = h_r[k-1]; end
      h_v[0] = int'(bus.in_valid); h_nd[0] = int'(bus.new_dist); h_r[0] = int'(bus.r);
      m_rpipe = h_r[NP-1];
    end
  end

  always @(negedge clock) begin : p_compare
    logic [NP*AW-1:0] ev;
    if (m_live) begin
      for (int i = 0; i < NP; i++) ev[i*AW +: AW] = AW'(m_res[i]);
      chk("acc_valid",  bus.acc_valid,  m_av);
      chk("acc_result", bus.acc_result, ev);
      chk("best_valid", bus.best_valid, m_bv);
      chk("best_sad",   bus.best_sad,   m_bsad);
      chk("best_idx",   bus.best_idx,   m_bidx);
      chk("overrun",    bus.overrun,    m_ovr);
      chk("r_pipe",     bus.r_pipe,     m_rpipe);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic v, input logic nd, input logic [PW-1:0] rr);
    @(negedge clock);
    bus.in_valid = v;
    bus.new_dist = nd;
    bus.r        = rr;
    #1;
  endtask

  task automatic block(input logic [PW-1:0] rr);
    tick(1, 1, rr);
    repeat (BP - 1) tick(1, 0, rr);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, bus.r);
  endtask

  task automatic chk_all(input string nm, input int e);
    for (int i = 0; i < NP; i++) chk(nm, bus.acc_result[i*AW +: AW], e);
  endtask

  initial begin
    int e8;
    reset_n = 1'b0;
    bus.in_valid = 0; bus.new_dist = 0; bus.r = '0;
    bus.s1 = '0; bus.s2 = '0; bus.s1s2_mux = '0;
    idle(2);
    chk("rst_acc_result", bus.acc_result, 0);
    chk("rst_acc_valid",  bus.acc_valid,  0);
    chk("rst_best",       {bus.best_valid, bus.best_sad, bus.best_idx}, 0);
    chk("rst_ovr_rpipe",  {bus.overrun, bus.r_pipe}, 0);
    reset_n = 1'b1;

    // Basic SAD: PE0/PE2 on s2 -> |10-3|*4 = 28, PE1/PE3 on s1 -> 0.
    bus.s1 = 8'd10; bus.s2 = 8'd3; bus.s1s2_mux = 4'b0101;
    block(8'd10);
    tick(0, 0, 10); chk("basic_av0", bus.acc_valid, 4'b0001);
    tick(0, 0, 10); chk("basic_av1", bus.acc_valid, 4'b0010);
    tick(0, 0, 10); chk("basic_av2", bus.acc_valid, 4'b0100);
    tick(0, 0, 10); chk("basic_av3", bus.acc_valid, 4'b1000);
    tick(0, 0, 10);
    chk("basic_bv",  bus.best_valid, 1);
    chk("basic_sad", bus.best_sad, 0);
    chk("basic_idx", bus.best_idx, 1);
    chk("basic_res", bus.acc_result, {16'd0, 16'd28, 16'd0, 16'd28});
    idle(2);

    // Back-to-back: r=10 block then r=0 block; second gives 12 (s2=3) / 40 (s1=10).
    block(8'd10);
    block(8'd0);
    tick(0, 0, 0);
    chk("b2b_first_bv",  bus.best_valid, 1);
    chk("b2b_first_sad", bus.best_sad, 0);
    chk("b2b_first_idx", bus.best_idx, 1);
    chk("b2b_mixed_res", bus.acc_result, {16'd0, 16'd28, 16'd0, 16'd12});
    idle(3);
    tick(0, 0, 0);
    chk("b2b_second_bv",  bus.best_valid, 1);
    chk("b2b_second_sad", bus.best_sad, 12);
    chk("b2b_second_idx", bus.best_idx, 0);
    chk("b2b_second_res", bus.acc_result, {16'd40, 16'd12, 16'd40, 16'd12});
    idle(2);

    // 255 x 4 = 1020: fits in 16 bits, wraps to 252 or saturates at 255 in 8 bits.
    bus.s1 = '0; bus.s2 = '0; bus.s1s2_mux = '0;
    block(8'd255);
    idle(8);
    chk_all("wide_res", 1020);
    chk("wide_best", bus.best_sad, 1020);
`ifdef SAD_SATURATE_EN
    e8 = 255;
`else
    e8 = 252;
`endif
    for (int i = 0; i < NP; i++) chk("narrow_res", bus8.acc_result[i*8 +: 8], e8);
    chk("narrow_best", bus8.best_sad, e8);

    // Fifth sample without new_dist: overrun, results held.
    chk("pre_overrun", bus.overrun, 0);
    tick(1, 0, 8'd255);
    idle(5);
    chk("overrun_set", bus.overrun, 1);
    chk_all("overrun_res_held", 1020);

    // Early restart after 2 samples; following block of r=2 gives 8.
    tick(1, 1, 8'd1); tick(1, 0, 8'd1);
    block(8'd2);
    idle(8);
    chk_all("restart_res", 8);
    chk("restart_best", bus.best_sad, 8);
    chk("restart_overrun_sticky", bus.overrun, 1);

    // Reset after two samples of a block.
    tick(1, 1, 8'd3); tick(1, 0, 8'd3);
    tick(0, 0, 8'd3); reset_n = 1'b0;
    tick(0, 0, 8'd3);
    chk("midrst_res", bus.acc_result, 0);
    chk("midrst_ovr", bus.overrun, 0);
    chk("midrst_best", {bus.best_valid, bus.best_sad, bus.best_idx}, 0);
    chk("midrst_av_rpipe", {bus.acc_valid, bus.r_pipe}, 0);
    reset_n = 1'b1;
    idle(4);
    block(8'd5);
    idle(8);
    chk_all("postrst_res", 20);
    chk("postrst_best", bus.best_sad, 20);

    // Two-cycle gap inside a block pushes acc_valid[0] from cycle 4 to cycle 6.
    tick(1, 1, 8'd7); tick(1, 0, 8'd7);
    tick(0, 0, 8'd7); tick(0, 0, 8'd7);
    tick(1, 0, 8'd7);
    chk("gap_no_early_av", bus.acc_valid, 0);
    tick(1, 0, 8'd7);
    tick(0, 0, 8'd7);
    chk("gap_av0", bus.acc_valid, 4'b0001);
    chk("gap_res0", bus.acc_result[AW-1:0], 28);
    idle(8);
    chk_all("gap_res", 28);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
